// File: rtl/dac_code_gen.sv
// -----------------------------------------------------------------------------
// dac_code_gen
// Generates the 8-bit sample code for the dac8bit converter model. Four
// waveforms are available: ramp, triangle, square and single sweep. A sample
// advances once every (div + 1) clocks. A configuration is accepted over a
// valid/ready handshake, and only while the block is idle.
//
// Ports
//   clk           system clock, rising-edge active
//   rst           synchronous, active-high reset
//   cfg_valid     configuration offered
//   cfg_ready     configuration can be accepted (high only when idle)
//   cfg_mode      0 ramp, 1 triangle, 2 square, 3 single sweep
//   cfg_step      code increment, or half-period in samples for square (0 -> 1)
//   cfg_div       prescaler: one sample every cfg_div+1 clocks
//   stop          abort the running sequence (D returns to 0)
//   D             DAC code, registered
//   sample_strobe one-cycle pulse in the first cycle D holds a new sample
//   busy          high while a sequence runs
//   done          one-cycle pulse together with the final 255 of a sweep
// -----------------------------------------------------------------------------
module dac_code_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [7:0]       cfg_step,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             stop,
    output logic [7:0]       D,
    output logic             sample_strobe,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_RAMP   = 2'd0;
    localparam logic [1:0] MODE_TRI    = 2'd1;
    localparam logic [1:0] MODE_SQUARE = 2'd2;
    localparam logic [1:0] MODE_SWEEP  = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    state_t           state_r, state_s;
    logic [7:0]       d_r, d_s;
    logic [DIV_W-1:0] cnt_r, cnt_s;
    logic             dir_r, dir_s;
    logic [7:0]       sq_r, sq_s;
    logic [1:0]       mode_r, mode_s;
    logic [7:0]       step_r, step_s;
    logic [DIV_W-1:0] div_r, div_s;
    logic             strobe_r, strobe_s;
    logic             done_r, done_s;
    logic             busy_r, busy_s;
    logic             ready_r, ready_s;

    // 9-bit intermediates so that saturation can see the carry and the borrow
    logic [8:0]       sum_s;
    logic [8:0]       diff_s;
    logic [7:0]       sq_inc_s;

    assign sum_s    = {1'b0, d_r} + {1'b0, step_r};
    assign diff_s   = {1'b0, d_r} - {1'b0, step_r};
    assign sq_inc_s = sq_r + 8'd1;

    // Next-state and next-output logic for the IDLE/RUN controller
    always_comb begin
        state_s  = state_r;
        d_s      = d_r;
        cnt_s    = cnt_r;
        dir_s    = dir_r;
        sq_s     = sq_r;
        mode_s   = mode_r;
        step_s   = step_r;
        div_s    = div_r;
        strobe_s = 1'b0;
        done_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (cfg_valid && ready_r) begin
                    state_s = ST_RUN;
                    mode_s  = cfg_mode;
                    step_s  = (cfg_step == 8'd0) ? 8'd1 : cfg_step;
                    div_s   = cfg_div;
                    d_s     = 8'd0;
                    cnt_s   = {DIV_W{1'b0}};
                    dir_s   = DIR_UP;
                    sq_s    = 8'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_s = ST_IDLE;
                    d_s     = 8'd0;
                end else if ((mode_r == MODE_SWEEP) && (d_r == 8'hFF)) begin
                    // A sweep only reaches 255 on its final sample; D holds it
                    state_s = ST_IDLE;
                end else if (cnt_r == div_r) begin
                    cnt_s    = {DIV_W{1'b0}};
                    strobe_s = 1'b1;
                    case (mode_r)
                        MODE_RAMP: begin
                            d_s = sum_s[7:0];
                        end
                        MODE_TRI: begin
                            if (dir_r == DIR_UP) begin
                                if (sum_s >= 9'd255) begin
                                    d_s   = 8'hFF;
                                    dir_s = DIR_DOWN;
                                end else begin
                                    d_s = sum_s[7:0];
                                end
                            end else begin
                                if (diff_s[8] || (diff_s[7:0] == 8'd0)) begin
                                    d_s   = 8'd0;
                                    dir_s = DIR_UP;
                                end else begin
                                    d_s = diff_s[7:0];
                                end
                            end
                        end
                        MODE_SQUARE: begin
                            if (sq_inc_s == step_r) begin
                                sq_s = 8'd0;
                                d_s  = (d_r == 8'h00) ? 8'hFF : 8'h00;
                            end else begin
                                sq_s = sq_inc_s;
                            end
                        end
                        MODE_SWEEP: begin
                            if (sum_s >= 9'd255) begin
                                d_s    = 8'hFF;
                                done_s = 1'b1;
                            end else begin
                                d_s = sum_s[7:0];
                            end
                        end
                        default: begin
                            d_s = sum_s[7:0];
                        end
                    endcase
                end else begin
                    cnt_s = cnt_r + DIV_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        ready_s = (state_s == ST_IDLE);
        busy_s  = (state_s == ST_RUN);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            d_r      <= 8'd0;
            cnt_r    <= {DIV_W{1'b0}};
            dir_r    <= DIR_UP;
            sq_r     <= 8'd0;
            mode_r   <= MODE_RAMP;
            step_r   <= 8'd1;
            div_r    <= {DIV_W{1'b0}};
            strobe_r <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            ready_r  <= 1'b1;
        end else begin
            state_r  <= state_s;
            d_r      <= d_s;
            cnt_r    <= cnt_s;
            dir_r    <= dir_s;
            sq_r     <= sq_s;
            mode_r   <= mode_s;
            step_r   <= step_s;
            div_r    <= div_s;
            strobe_r <= strobe_s;
            done_r   <= done_s;
            busy_r   <= busy_s;
            ready_r  <= ready_s;
        end
    end

    assign D             = d_r;
    assign sample_strobe = strobe_r;
    assign done          = done_r;
    assign busy          = busy_r;
    assign cfg_ready     = ready_r;

endmodule

// File: tb/tb_dac_code_gen.sv
// -----------------------------------------------------------------------------
// tb_dac_code_gen
// Self-checking bench for dac_code_gen. Expected codes are queued when a
// configuration is driven and popped whenever the DUT raises sample_strobe.
// -----------------------------------------------------------------------------
module tb_dac_code_gen;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_step;
    logic [15:0] cfg_div;
    logic        stop;
    logic [7:0]  D;
    logic        sample_strobe;
    logic        busy;
    logic        done;

    int n_checks;
    int n_fail;
    logic [7:0] exp_q[$];

    dac_code_gen #(.DIV_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_mode      (cfg_mode),
        .cfg_step      (cfg_step),
        .cfg_div       (cfg_div),
        .stop          (stop),
        .D             (D),
        .sample_strobe (sample_strobe),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are read and inputs driven 1 ns after the edge
    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // Offer one configuration for exactly one edge
    task automatic accept(input logic [1:0] m, input logic [7:0] s, input logic [15:0] dv);
        cfg_mode  = m;
        cfg_step  = s;
        cfg_div   = dv;
        cfg_valid = 1'b1;
        step_clk();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_valid = 1'b1; cfg_mode = 2'd0; cfg_step = 8'd1; cfg_div = 16'd0; stop = 1'b0;
        step_clk();
        step_clk();
        n_checks++; if (D !== 8'd0) begin n_fail++; $display("FAIL reset_D got=%0h exp=0", D); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (sample_strobe !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_pulses strobe=%b done=%b exp=0", sample_strobe, done); end
        rst = 1'b0; cfg_valid = 1'b0;
        step_clk();
        n_checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_no_accept busy=%b ready=%b exp=0/1", busy, cfg_ready); end
    endtask

    task automatic test_ramp();
        int nstb;
        logic [7:0] e;
        accept(2'd0, 8'd1, 16'd0);
        n_checks++; if (busy !== 1'b1 || cfg_ready !== 1'b0) begin n_fail++; $display("FAIL ramp_start busy=%b ready=%b exp=1/0", busy, cfg_ready); end
        n_checks++; if (D !== 8'd0 || sample_strobe !== 1'b0) begin n_fail++; $display("FAIL ramp_initial D=%0h strobe=%b exp=0/0", D, sample_strobe); end
        for (int v = 1; v <= 256; v++) exp_q.push_back(8'(v));
        nstb = 0;
        for (int c = 1; c <= 256; c++) begin
            step_clk();
            n_checks++; if (sample_strobe !== 1'b1) begin n_fail++; $display("FAIL ramp_strobe cycle=%0d got=%b exp=1", c, sample_strobe); end
            if (sample_strobe === 1'b1 && exp_q.size() > 0) begin
                nstb++;
                e = exp_q.pop_front();
                n_checks++; if (D !== e) begin n_fail++; $display("FAIL ramp_D cycle=%0d got=%0h exp=%0h", c, D, e); end
            end
        end
        n_checks++; if (nstb != 256 || exp_q.size() != 0) begin n_fail++; $display("FAIL ramp_count strobes=%0d exp=256 left=%0d", nstb, exp_q.size()); end
        exp_q.delete();
        stop = 1'b1;
        step_clk();
        stop = 1'b0;
        n_checks++; if (busy !== 1'b0 || D !== 8'd0 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL ramp_stop busy=%b D=%0h ready=%b exp=0/0/1", busy, D, cfg_ready); end
    endtask

    task automatic test_triangle();
        int gap;
        logic [7:0] e;
        logic [7:0] held;
        accept(2'd1, 8'd100, 16'd2);
        exp_q.push_back(8'd100); exp_q.push_back(8'd200); exp_q.push_back(8'd255);
        exp_q.push_back(8'd155); exp_q.push_back(8'd55);  exp_q.push_back(8'd0);
        exp_q.push_back(8'd100);
        gap = 0;
        held = 8'd0;
        for (int c = 1; c <= 40 && exp_q.size() > 0; c++) begin
            step_clk();
            gap++;
            if (sample_strobe === 1'b1) begin
                e = exp_q.pop_front();
                n_checks++; if (D !== e) begin n_fail++; $display("FAIL tri_D cycle=%0d got=%0d exp=%0d", c, D, e); end
                n_checks++; if (gap != 3) begin n_fail++; $display("FAIL tri_spacing cycle=%0d got=%0d exp=3", c, gap); end
                gap = 0;
                held = e;
            end else begin
                n_checks++; if (D !== held) begin n_fail++; $display("FAIL tri_hold cycle=%0d got=%0d exp=%0d", c, D, held); end
            end
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL tri_timeout left=%0d exp=0", exp_q.size()); end
        exp_q.delete();
        stop = 1'b1;
        step_clk();
        stop = 1'b0;
    endtask

    task automatic test_square();
        logic [7:0] e;
        accept(2'd2, 8'd3, 16'd0);
        n_checks++; if (D !== 8'h00) begin n_fail++; $display("FAIL sq_initial got=%0h exp=0", D); end
        for (int n = 1; n <= 12; n++) exp_q.push_back((((n / 3) % 2) == 1) ? 8'hFF : 8'h00);
        for (int c = 1; c <= 12; c++) begin
            step_clk();
            n_checks++; if (sample_strobe !== 1'b1) begin n_fail++; $display("FAIL sq_strobe cycle=%0d got=%b exp=1", c, sample_strobe); end
            e = exp_q.pop_front();
            n_checks++; if (D !== e) begin n_fail++; $display("FAIL sq_D cycle=%0d got=%0h exp=%0h", c, D, e); end
        end
        stop = 1'b1;
        step_clk();
        stop = 1'b0;
    endtask

    task automatic test_sweep();
        int ndone;
        logic [7:0] e;
        accept(2'd3, 8'd0, 16'd1);
        for (int v = 1; v <= 255; v++) exp_q.push_back(8'(v));
        // Offer a competing configuration for the first cycles of the sweep
        cfg_valid = 1'b1; cfg_mode = 2'd0; cfg_step = 8'd50; cfg_div = 16'd0;
        ndone = 0;
        for (int c = 1; c <= 510; c++) begin
            step_clk();
            if (c == 20) cfg_valid = 1'b0;
            n_checks++; if (sample_strobe !== ((c % 2) == 0)) begin n_fail++; $display("FAIL sweep_strobe cycle=%0d got=%b", c, sample_strobe); end
            n_checks++; if (done !== (c == 510)) begin n_fail++; $display("FAIL sweep_done cycle=%0d got=%b", c, done); end
            if (done === 1'b1) ndone++;
            if (c <= 20) begin
                n_checks++; if (busy !== 1'b1 || cfg_ready !== 1'b0) begin n_fail++; $display("FAIL sweep_no_accept cycle=%0d busy=%b ready=%b exp=1/0", c, busy, cfg_ready); end
            end
            if (sample_strobe === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++; if (D !== e) begin n_fail++; $display("FAIL sweep_D cycle=%0d got=%0d exp=%0d", c, D, e); end
            end
        end
        n_checks++; if (ndone != 1 || exp_q.size() != 0 || busy !== 1'b1) begin n_fail++; $display("FAIL sweep_end done=%0d left=%0d busy=%b exp=1/0/1", ndone, exp_q.size(), busy); end
        exp_q.delete();
        step_clk();
        n_checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1 || D !== 8'hFF || done !== 1'b0) begin n_fail++; $display("FAIL sweep_idle busy=%b ready=%b D=%0h done=%b exp=0/1/ff/0", busy, cfg_ready, D, done); end
        stop = 1'b1;
        step_clk();
        stop = 1'b0;
        n_checks++; if (D !== 8'hFF || busy !== 1'b0) begin n_fail++; $display("FAIL sweep_hold_stop D=%0h busy=%b exp=ff/0", D, busy); end
    endtask

    task automatic test_abort_reset();
        logic [7:0] e;
        accept(2'd0, 8'd5, 16'd4);
        exp_q.push_back(8'd5);
        for (int c = 1; c <= 9; c++) begin
            step_clk();
            n_checks++; if (sample_strobe !== (c == 5)) begin n_fail++; $display("FAIL abort_strobe cycle=%0d got=%b", c, sample_strobe); end
            if (sample_strobe === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++; if (D !== e) begin n_fail++; $display("FAIL abort_D cycle=%0d got=%0d exp=%0d", c, D, e); end
            end
        end
        exp_q.delete();
        // Cycle 9 is a tick cycle; stop must win over it
        stop = 1'b1;
        step_clk();
        stop = 1'b0;
        n_checks++; if (sample_strobe !== 1'b0 || D !== 8'd0 || busy !== 1'b0 || cfg_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL abort_stop strobe=%b D=%0h busy=%b ready=%b done=%b exp=0/0/0/1/0", sample_strobe, D, busy, cfg_ready, done);
        end
        accept(2'd0, 8'd5, 16'd4);
        for (int c = 1; c <= 7; c++) step_clk();
        n_checks++; if (D !== 8'd5 || busy !== 1'b1) begin n_fail++; $display("FAIL restart_run D=%0d busy=%b exp=5/1", D, busy); end
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
        n_checks++; if (D !== 8'd0 || busy !== 1'b0 || cfg_ready !== 1'b1 || sample_strobe !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL midrun_reset D=%0h busy=%b ready=%b strobe=%b done=%b exp=0/0/1/0/0", D, busy, cfg_ready, sample_strobe, done);
        end
        accept(2'd0, 8'd7, 16'd0);
        n_checks++; if (D !== 8'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL reaccept_start D=%0h busy=%b exp=0/1", D, busy); end
        exp_q.push_back(8'd7); exp_q.push_back(8'd14); exp_q.push_back(8'd21);
        for (int c = 1; c <= 3; c++) begin
            step_clk();
            e = exp_q.pop_front();
            n_checks++; if (D !== e || sample_strobe !== 1'b1) begin n_fail++; $display("FAIL reaccept_D cycle=%0d got=%0d strobe=%b exp=%0d/1", c, D, sample_strobe, e); end
        end
        stop = 1'b1;
        step_clk();
        stop = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_ramp();
        test_triangle();
        test_square();
        test_sweep();
        test_abort_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
